// File: rtl/column_parity_if.sv
// Handshake and lane-RAM bus between the round controller/state RAM and column_parity_unit.
interface column_parity_if #(
  parameter int LANE_W = 64
);
  logic              start;
  logic              ready;
  logic [4:0]        mem_addr;
  logic [LANE_W-1:0] mem_rd_data;
  logic [LANE_W-1:0] mem_wr_data;
  logic              mem_we;

  // master: round controller plus state RAM; slave: the theta unit
  modport master (output start, mem_rd_data, input ready, mem_addr, mem_wr_data, mem_we);
  modport slave  (input start, mem_rd_data, output ready, mem_addr, mem_wr_data, mem_we);
endinterface

// File: rtl/column_parity_unit.sv
// Theta step: column parities C[x], D[x] = C[x-1] ^ rotl(C[x+1],1), then A[x][y] ^= D[x] in RAM.
// Define COLPAR_DBG_EN to expose the latched column parities on the col_par port.
module column_parity_unit #(
  parameter int LANE_W = 64
) (
  input logic clk,
  input logic rst,
  column_parity_if.slave bus
`ifdef COLPAR_DBG_EN
  , output logic [5*LANE_W-1:0] col_par
`endif
);

  typedef enum logic [2:0] {IDLE, ACC, DRAIN, DCALC, RD, WR} state_t;

  state_t            state_q;
  logic              ready_q;
  logic              we_q;
  logic [4:0]        addr_q;
  logic [2:0]        x_q;
  logic [2:0]        y_q;
  logic [2:0]        x_prev_q;
  logic [LANE_W-1:0] c_q   [5];
  logic [LANE_W-1:0] d_q   [5];
  logic [LANE_W-1:0] c_nxt [5];

  function automatic logic [LANE_W-1:0] rotl1(input logic [LANE_W-1:0] v);
    return {v[LANE_W-2:0], v[LANE_W-1]};
  endfunction

  // Read data trails the address by one cycle, so it belongs to the lane at x_prev_q.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    for (int i = 0; i < 5; i++) c_nxt[i] = c_q[i];
    if ((state_q == ACC && addr_q != 5'd0) || state_q == DRAIN)
      c_nxt[x_prev_q] = c_q[x_prev_q] ^ bus.mem_rd_data;
  end

  assign bus.ready       = ready_q;
  assign bus.mem_we      = we_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wr_data = (state_q == WR) ? (bus.mem_rd_data ^ d_q[x_q]) : '0;

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ready_q  <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      x_prev_q <= '0;
      for (int i = 0; i < 5; i++) begin
        c_q[i] <= '0;
        d_q[i] <= '0;
      end
`ifdef COLPAR_DBG_EN
      col_par  <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q <= ACC;
            ready_q <= 1'b0;
            addr_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            for (int i = 0; i < 5; i++) c_q[i] <= '0;
          end
        end
        ACC: begin
          for (int i = 0; i < 5; i++) c_q[i] <= c_nxt[i];
          x_prev_q <= x_q;
          if (addr_q == 5'd24) begin
            state_q <= DRAIN;
          end else begin
            addr_q <= addr_q + 5'd1;
            if (x_q == 3'd4) begin
              x_q <= '0;
              y_q <= y_q + 3'd1;
            end else begin
              x_q <= x_q + 3'd1;
            end
          end
        end
        DRAIN: begin
          for (int i = 0; i < 5; i++) c_q[i] <= c_nxt[i];
`ifdef COLPAR_DBG_EN
          for (int i = 0; i < 5; i++) col_par[i*LANE_W +: LANE_W] <= c_nxt[i];
`endif
          state_q <= DCALC;
        end
        DCALC: begin
          for (int i = 0; i < 5; i++) d_q[i] <= c_q[(i + 4) % 5] ^ rotl1(c_q[(i + 1) % 5]);
          state_q <= RD;
          addr_q  <= '0;
          x_q     <= '0;
          y_q     <= '0;
        end
        RD: begin
          we_q    <= 1'b1;
          state_q <= WR;
        end
        WR: begin
          we_q <= 1'b0;
          if (addr_q == 5'd24) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            addr_q  <= '0;
          end else begin
            state_q <= RD;
            addr_q  <= addr_q + 5'd1;
            if (x_q == 3'd4) begin
              x_q <= '0;
              y_q <= y_q + 3'd1;
            end else begin
              x_q <= x_q + 3'd1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          we_q    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_column_parity_unit.sv
// Directed self-checking bench for column_parity_unit (LANE_W=64 and LANE_W=8 instances).
module tb_column_parity_unit;

  typedef logic [63:0] img_t [25];
  typedef logic [7:0]  img8_t [25];

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  column_parity_if #(.LANE_W(64)) bus  ();
  column_parity_if #(.LANE_W(8))  bus8 ();

`ifdef COLPAR_DBG_EN
  logic [319:0] col_par;
  logic [39:0]  col_par8;
  column_parity_unit #(.LANE_W(64)) dut  (.clk(clk), .rst(rst), .bus(bus),  .col_par(col_par));
  column_parity_unit #(.LANE_W(8))  dut8 (.clk(clk), .rst(rst), .bus(bus8), .col_par(col_par8));
`else
  column_parity_unit #(.LANE_W(64)) dut  (.clk(clk), .rst(rst), .bus(bus));
  column_parity_unit #(.LANE_W(8))  dut8 (.clk(clk), .rst(rst), .bus(bus8));
`endif

  // Synchronous-read state RAM models with a one-cycle bulk load port
  img_t  ram, load_img;
  img8_t ram8, load_img8;
  logic  load = 1'b0, load8 = 1'b0;
  int    wr_cnt = 0;

  always @(posedge clk) begin
    if (load) ram <= load_img;
    else if (bus.mem_we) begin
      ram[bus.mem_addr] <= bus.mem_wr_data;
      wr_cnt <= wr_cnt + 1;
    end
    bus.mem_rd_data <= ram[bus.mem_addr];
  end

  always @(posedge clk) begin
    if (load8) ram8 <= load_img8;
    else if (bus8.mem_we) ram8[bus8.mem_addr] <= bus8.mem_wr_data;
    bus8.mem_rd_data <= ram8[bus8.mem_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic theta_ref(input img_t a, output img_t r);
    logic [63:0] c [5];
    logic [63:0] d [5];
    for (int x = 0; x < 5; x++) begin
      c[x] = '0;
      for (int y = 0; y < 5; y++) c[x] ^= a[5*y + x];
    end
    for (int x = 0; x < 5; x++) begin
      d[x] = c[(x + 4) % 5] ^ {c[(x + 1) % 5][62:0], c[(x + 1) % 5][63]};
    end
    for (int i = 0; i < 25; i++) r[i] = a[i] ^ d[i % 5];
  endtask

  task automatic load_ram(input img_t img);
    load_img = img;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Pulse start for one cycle and count cycles with ready low (bounded)
  task automatic run_pass(output int low);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    low = 0;
    while (bus.ready === 1'b0 && low < 300) begin
      low++;
      @(negedge clk);
    end
  endtask

  task automatic check_ram(input string tag, input img_t exp);
    for (int i = 0; i < 25; i++) check($sformatf("%s lane %0d", tag, i), ram[i], exp[i]);
  endtask

  img_t img, exp, tmp;
  img8_t exp8;
  int low, low2, high, w0;

  initial begin
    bus.start  = 1'b0;
    bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("reset ready", 64'(bus.ready), 64'd1);
    check("reset we", 64'(bus.mem_we), 64'd0);
    check("reset addr", 64'(bus.mem_addr), 64'd0);
    check("reset wr_data", bus.mem_wr_data, 64'd0);
`ifdef COLPAR_DBG_EN
    check("reset col_par[0]", col_par[63:0], 64'd0);
`endif

    // All zeros: 77-cycle pass, 25 writes, nothing changes
    for (int i = 0; i < 25; i++) img[i] = '0;
    load_ram(img);
    w0 = wr_cnt;
    run_pass(low);
    check("zero latency", 64'(low), 64'd77);
    check("zero write count", 64'(wr_cnt - w0), 64'd25);
    check_ram("zero", img);

    // All ones: every column parity all-ones, D=0, nothing changes
    for (int i = 0; i < 25; i++) img[i] = '1;
    load_ram(img);
    run_pass(low);
    check("ones latency", 64'(low), 64'd77);
    check_ram("ones", img);
`ifdef COLPAR_DBG_EN
    check("ones col_par[4]", col_par[319:256], '1);
`endif

    // Single set bit in lane 0: hand-computed result
    for (int i = 0; i < 25; i++) begin
      img[i] = '0;
      exp[i] = '0;
    end
    img[0] = 64'h1;
    for (int y = 0; y < 5; y++) begin
      exp[5*y + 1] = 64'h1;
      exp[5*y + 4] = 64'h2;
    end
    exp[0] = 64'h1;
    load_ram(img);
    run_pass(low);
    check("lane0 latency", 64'(low), 64'd77);
    check_ram("lane0", exp);
`ifdef COLPAR_DBG_EN
    check("lane0 col_par[0]", col_par[63:0], 64'h1);
    check("lane0 col_par[1]", col_par[127:64], 64'h0);
    check("lane0 col_par[4]", col_par[319:256], 64'h0);
`endif

    // Random state against the reference model
    for (int i = 0; i < 25; i++) img[i] = {$urandom, $urandom};
    theta_ref(img, exp);
    load_ram(img);
    run_pass(low);
    check("rand latency", 64'(low), 64'd77);
    check_ram("rand", exp);

    // start held high: two back-to-back passes with a single ready-high cycle between
    for (int i = 0; i < 25; i++) img[i] = {$urandom, $urandom};
    theta_ref(img, tmp);
    theta_ref(tmp, exp);
    load_ram(img);
    bus.start = 1'b1;
    @(negedge clk);
    low = 0;
    while (bus.ready === 1'b0 && low < 300) begin
      low++;
      @(negedge clk);
    end
    high = 0;
    while (bus.ready === 1'b1 && high < 10) begin
      high++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    low2 = 0;
    while (bus.ready === 1'b0 && low2 < 300) begin
      low2++;
      @(negedge clk);
    end
    check("held first latency", 64'(low), 64'd77);
    check("held ready gap", 64'(high), 64'd1);
    check("held second latency", 64'(low2), 64'd77);
    check_ram("held twice", exp);

    // Reset in the RD/WR phase, then a full clean pass
    for (int i = 0; i < 25; i++) img[i] = {$urandom, $urandom};
    load_ram(img);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (39) @(negedge clk);
    check("midrst busy", 64'(bus.ready), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst ready", 64'(bus.ready), 64'd1);
    check("midrst we", 64'(bus.mem_we), 64'd0);
    repeat (3) @(negedge clk);
    check("midrst stays idle", 64'(bus.ready), 64'd1);
    for (int i = 0; i < 25; i++) img[i] = {$urandom, $urandom};
    theta_ref(img, exp);
    load_ram(img);
    run_pass(low);
    check("postrst latency", 64'(low), 64'd77);
    check_ram("postrst", exp);

    // LANE_W=8: lane 2 = 8'h80 -> x=1 lanes 8'h01, x=3 lanes 8'h80
    for (int i = 0; i < 25; i++) begin
      load_img8[i] = '0;
      exp8[i] = '0;
    end
    load_img8[2] = 8'h80;
    for (int y = 0; y < 5; y++) begin
      exp8[5*y + 1] = 8'h01;
      exp8[5*y + 3] = 8'h80;
    end
    exp8[2] = 8'h80;
    load8 = 1'b1;
    @(negedge clk);
    load8 = 1'b0;
    bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    low = 0;
    while (bus8.ready === 1'b0 && low < 300) begin
      low++;
      @(negedge clk);
    end
    check("w8 latency", 64'(low), 64'd77);
    for (int i = 0; i < 25; i++) check($sformatf("w8 lane %0d", i), 64'(ram8[i]), 64'(exp8[i]));
`ifdef COLPAR_DBG_EN
    check("w8 col_par", 64'(col_par8), 64'(40'h00_0080_0000));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
